var_node_serial: RTL and testbench



---
 rtl/var_node_serial_if.sv | 34 +++
 rtl/var_node_serial.sv | 156 +++++++++++++++
 tb/tb_var_node_serial.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/var_node_serial_if.sv
// Handshake and data bundle between the min-node stage and the serial
// variable-node processor. master drives node starts and check messages and
// consumes extrinsics; slave is the variable-node processor itself.
interface var_node_serial_if #(
  parameter int INT     = 8,
  parameter int FRAC    = 8,
  parameter int MAX_DEG = 8,
  parameter int W       = INT + FRAC,
  parameter int DW      = $clog2(MAX_DEG + 1)
);
  logic          start;
  logic [W-1:0]  llr_in;
  logic [DW-1:0] deg;
  logic          in_valid;
  logic [W-1:0]  in_msg;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_msg;
  logic          out_last;
  logic          out_ready;
  logic          hard_bit;
  logic          done;
  logic          err;

  modport master (
    output start, llr_in, deg, in_valid, in_msg, out_ready,
    input  in_ready, out_valid, out_msg, out_last, hard_bit, done, err
  );

  modport slave (
    input  start, llr_in, deg, in_valid, in_msg, out_ready,
    output in_ready, out_valid, out_msg, out_last, hard_bit, done, err
  );
endinterface

// File: rtl/var_node_serial.sv
// Serial min-sum variable node: accumulates channel LLR plus up to MAX_DEG
// check messages, then streams saturated extrinsics (total minus own input)
// and a registered hard decision.
module var_node_serial #(
  parameter int INT     = 8,
  parameter int FRAC    = 8,
  parameter int MAX_DEG = 8
) (
  input logic             clk,
  input logic             rst,
  var_node_serial_if.slave bus
);
  localparam int W  = INT + FRAC;
  localparam int DW = $clog2(MAX_DEG + 1);
  localparam int AW = W + DW + 1;
  localparam int IW = (MAX_DEG > 1) ? $clog2(MAX_DEG) : 1;

  // Symmetric clamp so that -2^(W-1) is never emitted.
  localparam logic signed [AW-1:0] SAT_HI = AW'((1 << (W - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_SUM,
    S_EMIT
  } state_t;

  state_t                 state_q, state_d;
  logic   [W-1:0]         msg_buf [MAX_DEG];
  logic signed [AW-1:0]   acc;
  logic   [DW-1:0]        deg_q;
  logic   [DW-1:0]        cnt;
  logic   [DW-1:0]        idx;
  logic   [DW-1:0]        cnt_inc;
  logic   [DW-1:0]        idx_inc;
  logic   [IW-1:0]        sel;
  logic                   deg_ok;
  logic                   in_fire;
  logic                   out_fire;
  logic signed [AW-1:0]   diff;
  logic   [W-1:0]         sat_diff;

  function automatic logic signed [AW-1:0] sext(input logic [W-1:0] v);
    return {{(AW-W){v[W-1]}}, v};
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [AW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[W-1:0];
    else if (v < SAT_LO) return SAT_LO[W-1:0];
    else                 return v[W-1:0];
  endfunction

  assign deg_ok  = (bus.deg != '0) && (bus.deg <= DW'(MAX_DEG));
  assign cnt_inc = cnt + DW'(1);
  assign idx_inc = idx + DW'(1);
  // SUM reads entry 0; EMIT prefetches the entry for the next output.
  // The wrapped index after the final output is never consumed.
  assign sel      = (state_q == S_SUM) ? '0 : idx_inc[IW-1:0];
  assign diff     = acc - sext(msg_buf[sel]);
  assign sat_diff = sat(diff);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d       = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    in_fire       = 1'b0;
    out_fire      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && deg_ok) state_d = S_ACCUM;
      end
      S_ACCUM: begin
        bus.in_ready = 1'b1;
        in_fire      = bus.in_valid;
        if (in_fire && (cnt_inc == deg_q)) state_d = S_SUM;
      end
      S_SUM: begin
        state_d = S_EMIT;
      end
      S_EMIT: begin
        bus.out_valid = 1'b1;
        out_fire      = bus.out_ready;
        if (out_fire && bus.out_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Message buffer; contents are don't-care outside a node.
  always_ff @(posedge clk) begin
    if (in_fire) msg_buf[cnt[IW-1:0]] <= bus.in_msg;
  end

  // Accumulator, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_msg  <= '0;
      bus.out_last <= 1'b0;
      bus.hard_bit <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.deg == '0) begin
              bus.hard_bit <= bus.llr_in[W-1];
              bus.done     <= 1'b1;
            end else if (!deg_ok) begin
              bus.err <= 1'b1;
            end else begin
              deg_q <= bus.deg;
              acc   <= sext(bus.llr_in);
              cnt   <= '0;
            end
          end
        end
        S_ACCUM: begin
          if (in_fire) begin
            acc <= acc + sext(bus.in_msg);
            cnt <= cnt_inc;
          end
        end
        S_SUM: begin
          bus.out_msg  <= sat_diff;
          bus.hard_bit <= acc[AW-1];
          idx          <= '0;
          bus.out_last <= (deg_q == DW'(1));
        end
        S_EMIT: begin
          if (out_fire) begin
            if (bus.out_last) begin
              bus.out_last <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              idx          <= idx_inc;
              bus.out_msg  <= sat_diff;
              bus.out_last <= (idx_inc == deg_q - DW'(1));
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_var_node_serial.sv
// Bench for the serial variable node: directed and random nodes checked
// against an integer-arithmetic reference of the extrinsic/hard-decision rules.
module tb_var_node_serial;
  localparam int INT     = 8;
  localparam int FRAC    = 8;
  localparam int MAX_DEG = 8;
  localparam int W       = INT + FRAC;
  localparam int DW      = $clog2(MAX_DEG + 1);
  localparam int SAT     = (1 << (W - 1)) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] msgs [MAX_DEG];

  var_node_serial_if #(.INT(INT), .FRAC(FRAC), .MAX_DEG(MAX_DEG)) bus ();

  var_node_serial #(.INT(INT), .FRAC(FRAC), .MAX_DEG(MAX_DEG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sat_w(input int v);
    int c;
    if (v > SAT)       c = SAT;
    else if (v < -SAT) c = -SAT;
    else               c = v;
    return c[W-1:0];
  endfunction

  function automatic int sval(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  // One node with msgs[0..deg-1]; starts in the current cycle (state IDLE).
  task automatic run_node(input logic [W-1:0] llr, input int deg, input bit gaps,
                          input int stall_idx, input int stall_len, input int abort_after);
    int total, acc_n, cyc, j, stall_rem, stalls;
    logic [W-1:0] exp_out [MAX_DEG];
    logic exp_hard;
    bit v, fire;
    total = sval(llr);
    for (int i = 0; i < deg; i++) total += sval(msgs[i]);
    for (int i = 0; i < deg; i++) exp_out[i] = sat_w(total - sval(msgs[i]));
    exp_hard = (total < 0);
    stalls = (stall_idx >= 0 && stall_idx < deg) ? stall_len : 0;

    bus.start  = 1'b1;
    bus.llr_in = llr;
    bus.deg    = DW'(deg);
    tick();
    bus.start = 1'b0;
    check("in_ready_rise", 32'(bus.in_ready), 32'd1);
    check("done_clear", 32'(bus.done), 32'd0);

    acc_n = 0;
    cyc   = 0;
    while (acc_n < deg && cyc < 400) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.in_valid = v;
      bus.in_msg   = msgs[acc_n];
      fire = v && bus.in_ready;
      tick();
      cyc++;
      if (fire) acc_n++;
    end
    bus.in_valid = 1'b0;
    bus.in_msg   = W'($urandom);
    check("in_count", 32'(acc_n), 32'(deg));
    check("sum_no_valid", 32'(bus.out_valid), 32'd0);
    tick();

    j = 0;
    cyc = 0;
    stall_rem = stall_len;
    while (j < deg && cyc < 400) begin
      if (abort_after >= 0 && j == abort_after) break;
      bus.out_ready = !(j == stall_idx && stall_rem > 0);
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("out_msg", 32'(bus.out_msg), 32'(exp_out[j]));
      check("out_last", 32'(bus.out_last), 32'(j == deg - 1));
      fire = bus.out_valid && bus.out_ready;
      tick();
      cyc++;
      if (fire) j++;
      else stall_rem--;
    end
    bus.out_ready = 1'b1;

    if (abort_after >= 0) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_msg", 32'(bus.out_msg), 32'd0);
      check("rst_out_last", 32'(bus.out_last), 32'd0);
      check("rst_hard_bit", 32'(bus.hard_bit), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      tick();
      check("rst_no_done", 32'(bus.done), 32'd0);
      check("rst_idle_valid", 32'(bus.out_valid), 32'd0);
    end else begin
      check("out_count", 32'(j), 32'(deg));
      check("out_cycles", 32'(cyc), 32'(deg + stalls));
      check("done_pulse", 32'(bus.done), 32'd1);
      check("valid_drop", 32'(bus.out_valid), 32'd0);
      check("hard_bit", 32'(bus.hard_bit), 32'(exp_hard));
    end
  endtask

  task automatic set_nominal();
    msgs[0] = 16'h0080;
    msgs[1] = 16'hFF00;
    msgs[2] = 16'h0200;
  endtask

  initial begin
    int d, si, sl;
    logic [W-1:0] l;
    bus.start     = 1'b0;
    bus.llr_in    = '0;
    bus.deg       = '0;
    bus.in_valid  = 1'b0;
    bus.in_msg    = '0;
    bus.out_ready = 1'b1;

    rst = 1'b1;
    tick();
    tick();
    check("reset_in_ready", 32'(bus.in_ready), 32'd0);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_msg", 32'(bus.out_msg), 32'd0);
    check("reset_out_last", 32'(bus.out_last), 32'd0);
    check("reset_hard_bit", 32'(bus.hard_bit), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_err", 32'(bus.err), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal node.
    set_nominal();
    run_node(16'h0100, 3, 1'b0, -1, 0, -1);

    // Positive and negative saturation.
    msgs[0] = 16'h7FFF; msgs[1] = 16'h7FFF;
    run_node(16'h7FFF, 2, 1'b0, -1, 0, -1);
    msgs[0] = 16'h8000; msgs[1] = 16'h8000;
    run_node(16'h8000, 2, 1'b0, -1, 0, -1);

    // Input gaps plus a five-cycle stall on the second output.
    set_nominal();
    run_node(16'h0100, 3, 1'b1, 1, 5, -1);

    // Full-degree node started in the done cycle of the previous one.
    for (int i = 0; i < MAX_DEG; i++) msgs[i] = 16'hFFFF;
    run_node(16'h0000, MAX_DEG, 1'b0, -1, 0, -1);

    // Degree zero: immediate hard decision from the LLR.
    bus.start = 1'b1; bus.llr_in = 16'h8123; bus.deg = '0;
    tick();
    bus.start = 1'b0;
    check("deg0_done", 32'(bus.done), 32'd1);
    check("deg0_hard", 32'(bus.hard_bit), 32'd1);
    check("deg0_valid", 32'(bus.out_valid), 32'd0);
    check("deg0_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("deg0_done_end", 32'(bus.done), 32'd0);

    // Degree above MAX_DEG: error pulse only.
    bus.start = 1'b1; bus.llr_in = 16'h0000; bus.deg = DW'(MAX_DEG + 1);
    tick();
    bus.start = 1'b0;
    check("err_pulse", 32'(bus.err), 32'd1);
    check("err_no_done", 32'(bus.done), 32'd0);
    check("err_in_ready", 32'(bus.in_ready), 32'd0);
    check("err_hard_kept", 32'(bus.hard_bit), 32'd1);
    tick();
    check("err_end", 32'(bus.err), 32'd0);
    check("err_still_idle", 32'(bus.in_ready), 32'd0);

    // Reset after the first output handshake, then a clean node.
    set_nominal();
    run_node(16'h0100, 3, 1'b0, -1, 0, 1);
    set_nominal();
    run_node(16'h0100, 3, 1'b0, -1, 0, -1);

    // Random nodes with saturation-biased values, gaps and stalls.
    for (int n = 0; n < 24; n++) begin
      d = $urandom_range(1, MAX_DEG);
      for (int i = 0; i < d; i++) begin
        case ($urandom_range(0, 7))
          0:       msgs[i] = 16'h8000;
          1:       msgs[i] = 16'h7FFF;
          default: msgs[i] = W'($urandom);
        endcase
      end
      l  = ($urandom_range(0, 5) == 0) ? 16'h8000 : W'($urandom);
      si = $urandom_range(0, 1) ? $urandom_range(0, d - 1) : -1;
      sl = $urandom_range(0, 4);
      run_node(l, d, 1'($urandom_range(0, 1)), si, sl, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
